window_gen: RTL

Upstream feeder for the 9-word kernel-window buffers of the 9x8 PE array. The block accepts a raster-order pixel stream, one DATA_WIDTH word per handshake. Two internal line buffers turn that stream into 3x3 sliding windows, with no padding. Each window is emitted as one packed DATA_WIDTH*9 word, which is the same format the controller loads into its per-kernel buffers.

---
 rtl/pe_array_pkg.sv | 19 +
 rtl/window_gen_line_buffer.sv | 32 +++
 rtl/window_gen.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pe_array_pkg.sv
// Shared types for the PE-array feeder path: pixel/window widths, window typedef, window_gen FSM states.
package pe_array_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int KERNEL_SIZE = 9;
    localparam int WIN_WIDTH   = DATA_WIDTH * KERNEL_SIZE;

    typedef logic [WIN_WIDTH-1:0] window_t;

    // [row][col] grid whose packed layout equals window_t: element [wr][wc] sits at word 3*wr+wc.
    typedef logic [2:0][2:0][DATA_WIDTH-1:0] win_grid_t;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wg_state_e;

endpackage

// File: rtl/window_gen_line_buffer.sv
// One-row pixel store: combinational read and clocked write at the same address,
// so a read in the write cycle returns the old contents.
module line_buffer
    import pe_array_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = DATA_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_gen.sv
// Raster pixel stream -> packed 3x3 sliding windows (no padding) with a single output register.
// Optional window counter port o_win_cnt is built when WIN_CNT_EN is defined.
module window_gen
    import pe_array_pkg::*;
#(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [DATA_WIDTH-1:0] i_pixel,
    output logic                  o_valid,
    input  logic                  o_ready,
    output window_t               o_window,
    output logic                  o_frame_done,
`ifdef WIN_CNT_EN
    output logic [15:0]           o_win_cnt,
`endif
    output wg_state_e             o_dbg_state
);

    localparam int LB_AW = $clog2(IMG_WIDTH);

    // Valid/ready: a transfer happens on any rising edge where valid && ready are both high;
    // the producer holds its payload stable from raising valid until that edge.

    wg_state_e state_q, state_d;
    logic [15:0] col_q, col_d;
    logic [15:0] row_q, row_d;
    win_grid_t win_q, win_d;
    logic o_valid_q, o_valid_d;
    window_t o_window_q, o_window_d;
    logic o_frame_done_q, o_frame_done_d;

    logic accept, col_last, row_last, last_pix, run_phase, load;
    logic [LB_AW-1:0] lb_addr;
    logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;

    assign i_ready  = !o_valid_q || o_ready;
    assign accept   = i_valid && i_ready;
    assign col_last = (col_q == 16'(IMG_WIDTH - 1));
    assign row_last = (row_q == 16'(IMG_HEIGHT - 1));
    assign last_pix = accept && col_last && row_last;
    assign lb_addr  = col_q[LB_AW-1:0];

    // lb0 is fed from lb1's old word, so the pair acts as a two-row delay line.
    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH), .AW(LB_AW)) u_lb0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .addr  (lb_addr),
        .wdata (lb1_rd),
        .rdata (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH), .AW(LB_AW)) u_lb1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .addr  (lb_addr),
        .wdata (i_pixel),
        .rdata (lb1_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (accept && col_last && row_q == 16'd1) state_d = RUN;
            RUN:     if (last_pix) state_d = DONE;
            DONE:    state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        run_phase = (state_q == RUN);
    end

    assign o_dbg_state = state_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 16'd1;
            end else begin
                col_d = col_q + 16'd1;
            end
        end
    end

    // Stale columns from the previous row are shifted out before c reaches 2, so no explicit flush is needed.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int wr = 0; wr < 3; wr++) begin
                win_d[wr][0] = win_q[wr][1];
                win_d[wr][1] = win_q[wr][2];
            end
            win_d[0][2] = lb0_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = i_pixel;
        end
    end

    assign load = accept && run_phase && (col_q >= 16'd2);

    always_comb begin
        o_valid_d      = load || (o_valid_q && !o_ready);
        o_window_d     = load ? window_t'(win_d) : o_window_q;
        o_frame_done_d = load && row_last && col_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q          <= '0;
            row_q          <= '0;
            win_q          <= '0;
            o_valid_q      <= 1'b0;
            o_window_q     <= '0;
            o_frame_done_q <= 1'b0;
        end else begin
            col_q          <= col_d;
            row_q          <= row_d;
            win_q          <= win_d;
            o_valid_q      <= o_valid_d;
            o_window_q     <= o_window_d;
            o_frame_done_q <= o_frame_done_d;
        end
    end

    assign o_valid      = o_valid_q;
    assign o_window     = o_window_q;
    assign o_frame_done = o_frame_done_q;

`ifdef WIN_CNT_EN
    logic [15:0] win_cnt_q, win_cnt_d;

    always_comb begin
        win_cnt_d = win_cnt_q;
        if (o_frame_done_q) begin
            win_cnt_d = load ? 16'd1 : 16'd0;
        end else if (load) begin
            win_cnt_d = win_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
        end
    end

    assign o_win_cnt = win_cnt_q;
`endif

endmodule
